// File: rtl/apb4_gpio_flt_pkg.sv
// Shared definitions for the filtered APB4 GPIO block.
//   - Register word indices (index = paddr[5:2]).
//   - Field positions inside DBCFG.
//   - Encoding of the per-pin {INTTYPE1, INTTYPE0} interrupt type.
package apb4_gpio_flt_pkg;

  localparam logic [3:0] IDX_PADDIR    = 4'd0;
  localparam logic [3:0] IDX_PADIN     = 4'd1;
  localparam logic [3:0] IDX_PADOUT    = 4'd2;
  localparam logic [3:0] IDX_INTEN     = 4'd3;
  localparam logic [3:0] IDX_INTTYPE0  = 4'd4;
  localparam logic [3:0] IDX_INTTYPE1  = 4'd5;
  localparam logic [3:0] IDX_INTSTATUS = 4'd6;
  localparam logic [3:0] IDX_IOFCFG    = 4'd7;
  localparam logic [3:0] IDX_OUTSET    = 4'd8;
  localparam logic [3:0] IDX_OUTCLR    = 4'd9;
  localparam logic [3:0] IDX_OUTTGL    = 4'd10;
  localparam logic [3:0] IDX_INTBOTH   = 4'd11;
  localparam logic [3:0] IDX_DBEN      = 4'd12;
  localparam logic [3:0] IDX_DBCFG     = 4'd13;

  // DBCFG layout: prescaler divider in the low half, threshold from bit 16.
  localparam int DBCFG_DIV_LSB = 0;
  localparam int DBCFG_DIV_W   = 16;
  localparam int DBCFG_THR_LSB = 16;

  typedef enum logic [1:0] {
    INT_LEVEL_HIGH = 2'b00,
    INT_LEVEL_LOW  = 2'b01,
    INT_RISE       = 2'b10,
    INT_FALL       = 2'b11
  } int_type_e;

endpackage

// File: rtl/apb4_gpio_flt_debounce.sv
// Per-pin GPIO debounce filter.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   tick       - prescaler strobe; the counter only advances on a tick
//   enable     - 1 = filter active, 0 = filt_q follows sync_in every cycle
//   threshold  - ticks of stable mismatch needed to flip (0 behaves as 1)
//   sync_in    - synchronised pad input
//   filt_q     - filtered value (registered)
//   filt_d     - value filt_q takes at the next edge, used for edge detection
module apb4_gpio_flt_debounce
  import apb4_gpio_flt_pkg::*;
#(
  parameter int DB_CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                enable,
  input  logic [DB_CNT_W-1:0] threshold,
  input  logic                sync_in,
  output logic                filt_q,
  output logic                filt_d
);

  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;
  logic [DB_CNT_W-1:0] thr_eff;
  logic [DB_CNT_W:0]   cnt_inc;

  assign thr_eff = (threshold == '0) ? {{(DB_CNT_W-1){1'b0}}, 1'b1} : threshold;
  // One bit wider so the compare cannot wrap at the top of the range.
  assign cnt_inc = {1'b0, cnt_q} + {{DB_CNT_W{1'b0}}, 1'b1};

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (!enable) begin
      filt_d = sync_in;
      cnt_d  = '0;
    end else if (sync_in == filt_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_inc >= {1'b0, thr_eff}) begin
        filt_d = ~filt_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_inc[DB_CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/apb4_gpio_flt.sv
// APB4 GPIO slave with input debounce, edge/level interrupts, atomic
// set/clear/toggle outputs and write-1-to-clear interrupt status.
// Ports:
//   pclk, preset          - clock, asynchronous active-high reset
//   paddr/psel/penable/pwrite/pwdata/prdata/pready/pslverr - APB4 slave
//   gpio_in_i             - raw asynchronous pad inputs
//   gpio_out_o            - pad output value
//   gpio_dir_o            - pad output enable (1 = output)
//   gpio_iof_o            - alternate function select
//   irq_o                 - registered level interrupt
module apb4_gpio_flt
  import apb4_gpio_flt_pkg::*;
#(
  parameter int GPIO_NUM    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 4
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [31:0]         paddr,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [31:0]         pwdata,
  output logic [31:0]         prdata,
  output logic                pready,
  output logic                pslverr,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_dir_o,
  output logic [GPIO_NUM-1:0] gpio_iof_o,
  output logic                irq_o
);

  logic                wr_en;
  logic                rd_en;
  logic [3:0]          idx;
  logic [GPIO_NUM-1:0] wd;
  logic                unused_addr;

  logic [GPIO_NUM-1:0] paddir, padout, inten, inttype0, inttype1;
  logic [GPIO_NUM-1:0] intstatus, iofcfg, intboth, dben;
  logic [DBCFG_DIV_W-1:0] db_div;
  logic [DB_CNT_W-1:0]    db_thr;

  logic [GPIO_NUM-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_NUM-1:0] sync;
  logic [GPIO_NUM-1:0] filt_q, filt_d;
  logic [GPIO_NUM-1:0] rise, fall, evt, w1c_mask;
  logic [DBCFG_DIV_W-1:0] pre_cnt;
  logic                tick;
  logic [31:0]         rd_data;

  assign pready  = 1'b1;
  assign pslverr = 1'b0;

  assign wr_en = psel & penable & pwrite;
  assign rd_en = psel & penable & ~pwrite;
  assign idx   = paddr[5:2];
  assign wd    = pwdata[GPIO_NUM-1:0];
  assign unused_addr = ^{paddr[31:6], paddr[1:0]};

  // Stage: input synchroniser chain.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end
  assign sync = sync_q[SYNC_STAGES-1];

  // Stage: debounce prescaler; restarts from 0 whenever DBCFG is written so
  // a new divider takes effect from a known phase.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      pre_cnt <= '0;
    end else if (wr_en && idx == IDX_DBCFG) begin
      pre_cnt <= '0;
    end else if (pre_cnt == db_div) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end
  assign tick = (pre_cnt == db_div);

  // Stage: per-pin filters.
  for (genvar g = 0; g < GPIO_NUM; g++) begin : g_flt
    apb4_gpio_flt_debounce #(.DB_CNT_W(DB_CNT_W)) u_flt (
      .clk       (pclk),
      .rst       (preset),
      .tick      (tick),
      .enable    (dben[g]),
      .threshold (db_thr),
      .sync_in   (sync[g]),
      .filt_q    (filt_q[g]),
      .filt_d    (filt_d[g])
    );
  end

  // Edges are taken against the filter's next value so the status bit sets
  // on the same edge that the filtered input changes.
  assign rise = ~filt_q & filt_d;
  assign fall = filt_q & ~filt_d;

  always_comb begin
    evt = '0;
    for (int i = 0; i < GPIO_NUM; i++) begin
      if (intboth[i]) begin
        evt[i] = rise[i] | fall[i];
      end else begin
        case (int_type_e'({inttype1[i], inttype0[i]}))
          INT_LEVEL_HIGH: evt[i] = filt_q[i];
          INT_LEVEL_LOW:  evt[i] = ~filt_q[i];
          INT_RISE:       evt[i] = rise[i];
          default:        evt[i] = fall[i];
        endcase
      end
    end
  end

  // Stage: register file.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      paddir   <= '0;
      padout   <= '0;
      inten    <= '0;
      inttype0 <= '0;
      inttype1 <= '0;
      iofcfg   <= '0;
      intboth  <= '0;
      dben     <= '0;
      db_div   <= '0;
      db_thr   <= '0;
    end else if (wr_en) begin
      case (idx)
        IDX_PADDIR:   paddir   <= wd;
        IDX_PADOUT:   padout   <= wd;
        IDX_INTEN:    inten    <= wd;
        IDX_INTTYPE0: inttype0 <= wd;
        IDX_INTTYPE1: inttype1 <= wd;
        IDX_IOFCFG:   iofcfg   <= wd;
        IDX_OUTSET:   padout   <= padout | wd;
        IDX_OUTCLR:   padout   <= padout & ~wd;
        IDX_OUTTGL:   padout   <= padout ^ wd;
        IDX_INTBOTH:  intboth  <= wd;
        IDX_DBEN:     dben     <= wd;
        IDX_DBCFG: begin
          db_div <= pwdata[DBCFG_DIV_LSB +: DBCFG_DIV_W];
          db_thr <= pwdata[DBCFG_THR_LSB +: DB_CNT_W];
        end
        default: ;
      endcase
    end
  end

  // Stage: interrupt status and output; a new event outranks a same-cycle clear.
  assign w1c_mask = (wr_en && idx == IDX_INTSTATUS) ? wd : '0;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      intstatus <= '0;
      irq_o     <= 1'b0;
    end else begin
      intstatus <= (intstatus & ~w1c_mask) | (inten & evt);
      irq_o     <= |(intstatus & inten);
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (idx)
        IDX_PADDIR:    rd_data[GPIO_NUM-1:0] = paddir;
        IDX_PADIN:     rd_data[GPIO_NUM-1:0] = filt_q;
        IDX_PADOUT:    rd_data[GPIO_NUM-1:0] = padout;
        IDX_INTEN:     rd_data[GPIO_NUM-1:0] = inten;
        IDX_INTTYPE0:  rd_data[GPIO_NUM-1:0] = inttype0;
        IDX_INTTYPE1:  rd_data[GPIO_NUM-1:0] = inttype1;
        IDX_INTSTATUS: rd_data[GPIO_NUM-1:0] = intstatus;
        IDX_IOFCFG:    rd_data[GPIO_NUM-1:0] = iofcfg;
        IDX_INTBOTH:   rd_data[GPIO_NUM-1:0] = intboth;
        IDX_DBEN:      rd_data[GPIO_NUM-1:0] = dben;
        IDX_DBCFG: begin
          rd_data[DBCFG_DIV_LSB +: DBCFG_DIV_W] = db_div;
          rd_data[DBCFG_THR_LSB +: DB_CNT_W]    = db_thr;
        end
        default: ;
      endcase
    end
  end
  assign prdata = rd_data;

  assign gpio_out_o = padout;
  assign gpio_dir_o = paddir;
  assign gpio_iof_o = iofcfg;

endmodule

// File: tb/tb_apb4_gpio_flt.sv
// Self-checking bench for apb4_gpio_flt (default parameters).
module tb_apb4_gpio_flt;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] gpio_in_i = '0;
  logic [31:0] gpio_out_o, gpio_dir_o, gpio_iof_o;
  logic        irq_o;

  int checks = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  apb4_gpio_flt #(.GPIO_NUM(32), .SYNC_STAGES(2), .DB_CNT_W(4)) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .gpio_in_i(gpio_in_i), .gpio_out_o(gpio_out_o),
    .gpio_dir_o(gpio_dir_o), .gpio_iof_o(gpio_iof_o), .irq_o(irq_o)
  );

  typedef struct {
    int          kind;  // 0 write, 1 read prdata, 2 gpio_out_o, 3 gpio_dir_o, 4 gpio_iof_o
    logic [3:0]  idx;
    logic [31:0] data;  // write data or expected value
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int k, input logic [3:0] i, input logic [31:0] d);
    vec_t v;
    v.kind = k; v.idx = i; v.data = d;
    vt.push_back(v);
  endtask

  task automatic apb_write(input logic [3:0] i, input logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {26'd0, i, 2'b00}; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] i, output logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {26'd0, i, 2'b00};
    @(negedge pclk);
    penable = 1'b1;
    #1 d = prdata;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] i, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(i, d);
    check(name, d, exp);
  endtask

  task automatic hold_read(input logic [3:0] i);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = {26'd0, i, 2'b00};
  endtask

  task automatic do_reset;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; gpio_in_i = '0;
    #2 preset = 1'b1;
    #1;
    check("rst_out", gpio_out_o, 32'h0);
    check("rst_dir", gpio_dir_o, 32'h0);
    check("rst_iof", gpio_iof_o, 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, m_out, base, st, f, f_prev, nv, exp_bit;
    logic [31:0] hist [0:201];
    logic        exp_irq;
    int          op, seen, first_k;

    // ---------------- reset + register table ----------------
    do_reset;
    check("pready", 32'(pready), 32'h1);
    check("pslverr", 32'(pslverr), 32'h0);

    add(0, 2, 32'h0000_00F0); add(0, 8, 32'h1); add(0, 9, 32'h10); add(0, 10, 32'h3);
    add(2, 0, 32'h0000_00E2); add(1, 2, 32'h0000_00E2);
    add(1, 8, 32'h0); add(1, 9, 32'h0); add(1, 10, 32'h0); add(1, 15, 32'h0);
    add(0, 15, 32'hFFFF_FFFF); add(1, 15, 32'h0);
    add(0, 0, 32'hA5A5_0F0F); add(3, 0, 32'hA5A5_0F0F); add(1, 0, 32'hA5A5_0F0F);
    add(0, 7, 32'h1234_5678); add(4, 0, 32'h1234_5678); add(1, 7, 32'h1234_5678);
    add(0, 14, 32'hFFFF_FFFF); add(1, 14, 32'h0); add(1, 0, 32'hA5A5_0F0F); add(2, 0, 32'h0000_00E2);
    add(0, 13, 32'hFFFF_FFFF); add(1, 13, 32'h000F_FFFF);
    add(0, 13, 32'h0); add(1, 13, 32'h0);
    add(0, 11, 32'hC000_0003); add(1, 11, 32'hC000_0003); add(0, 11, 32'h0);
    add(0, 4, 32'h5A5A_5A5A); add(1, 4, 32'h5A5A_5A5A);
    add(0, 5, 32'h3C3C_3C3C); add(1, 5, 32'h3C3C_3C3C);
    add(0, 4, 32'h0); add(0, 5, 32'h0);
    add(1, 1, 32'h0); add(0, 1, 32'hFFFF_FFFF); add(1, 1, 32'h0);
    add(1, 6, 32'h0); add(1, 3, 32'h0);

    foreach (vt[n]) begin
      case (vt[n].kind)
        0: apb_write(vt[n].idx, vt[n].data);
        1: read_check($sformatf("tbl_rd%0d_idx%0d", n, vt[n].idx), vt[n].idx, vt[n].data);
        2: check($sformatf("tbl_out%0d", n), gpio_out_o, vt[n].data);
        3: check($sformatf("tbl_dir%0d", n), gpio_dir_o, vt[n].data);
        default: check($sformatf("tbl_iof%0d", n), gpio_iof_o, vt[n].data);
      endcase
    end

    // ---------------- random atomic output ops vs model ----------------
    m_out = $urandom;
    apb_write(2, m_out);
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 3);
      d  = $urandom;
      case (op)
        0: begin apb_write(2, d);  m_out = d;          end
        1: begin apb_write(8, d);  m_out = m_out | d;  end
        2: begin apb_write(9, d);  m_out = m_out & ~d; end
        default: begin apb_write(10, d); m_out = m_out ^ d; end
      endcase
      check("rand_out", gpio_out_o, m_out);
    end

    // ---------------- rise interrupt latency and W1C ----------------
    do_reset;
    apb_write(3, 32'h1);
    apb_write(5, 32'h1);
    @(negedge pclk);
    hold_read(6);
    gpio_in_i[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge pclk);
      check($sformatf("rise_status_e%0d", k), prdata, (k >= 3) ? 32'h1 : 32'h0);
      check($sformatf("rise_irq_e%0d", k), 32'(irq_o), (k >= 4) ? 32'h1 : 32'h0);
    end
    pwrite = 1'b1; pwdata = 32'h1;
    @(negedge pclk);
    check("w1c_irq_still", 32'(irq_o), 32'h1);
    pwrite = 1'b0;
    #1 check("w1c_status", prdata, 32'h0);
    @(negedge pclk);
    check("w1c_irq_clear", 32'(irq_o), 32'h0);
    psel = 1'b0; penable = 1'b0;

    // ---------------- both-edge mode on pin 5 ----------------
    do_reset;
    apb_write(11, 32'h20);
    apb_write(3, 32'h20);
    @(negedge pclk);
    gpio_in_i[5] = 1'b1;
    repeat (4) @(negedge pclk);
    read_check("both_rise", 6, 32'h20);
    apb_write(6, 32'h20);
    gpio_in_i[5] = 1'b0;
    read_check("both_cleared", 6, 32'h0);
    repeat (3) @(negedge pclk);
    read_check("both_fall", 6, 32'h20);
    read_check("both_reread", 6, 32'h20);

    // ---------------- debounce: glitch rejection and threshold ----------------
    do_reset;
    apb_write(13, (32'd4 << 16) | 32'd3);
    apb_write(12, 32'h4);
    @(negedge pclk);
    hold_read(1);
    seen = 0;
    for (int k = 0; k < 36; k++) begin
      if (k == 0)  gpio_in_i[2] = 1'b1;
      if (k == 12) gpio_in_i[2] = 1'b0;
      @(negedge pclk);
      if (prdata[2]) seen = 1;
    end
    check("glitch_padin", 32'(seen), 32'h0);
    gpio_in_i[2] = 1'b1;
    first_k = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge pclk);
      if (prdata[2] && first_k == 0) first_k = k;
    end
    check("db_lat_min", 32'(first_k >= 15), 32'h1);
    check("db_lat_max", 32'(first_k <= 18), 32'h1);
    check("db_held", 32'(prdata[2]), 32'h1);
    psel = 1'b0; penable = 1'b0;

    // ---------------- level-low with continuous W1C: set wins ----------------
    do_reset;
    apb_write(3, 32'h80);
    apb_write(4, 32'h80);
    repeat (2) @(negedge pclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'd6 << 2; pwdata = 32'h80;
    for (int k = 0; k < 8; k++) begin
      @(negedge pclk);
      check($sformatf("lvl_irq%0d", k), 32'(irq_o), 32'h1);
    end
    pwrite = 1'b0;
    #1 check("lvl_status", prdata, 32'h80);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    apb_write(3, 32'h0);
    repeat (2) @(negedge pclk);
    check("mask_irq", 32'(irq_o), 32'h0);
    read_check("mask_status_kept", 6, 32'h80);

    // ---------------- reset mid-debounce ----------------
    do_reset;
    apb_write(13, (32'd4 << 16) | 32'd3);
    apb_write(12, 32'h4);
    apb_write(3, 32'h80);
    apb_write(4, 32'h80);
    apb_write(2, 32'hFF);
    apb_write(0, 32'h0F);
    apb_write(7, 32'h03);
    @(negedge pclk);
    gpio_in_i[2] = 1'b1;
    repeat (8) @(negedge pclk);
    check("pre_rst_irq", 32'(irq_o), 32'h1);
    hold_read(2);
    #1 check("pre_rst_prdata", prdata, 32'hFF);
    #2 preset = 1'b1;
    #1;
    check("async_rst_out", gpio_out_o, 32'h0);
    check("async_rst_dir", gpio_dir_o, 32'h0);
    check("async_rst_iof", gpio_iof_o, 32'h0);
    check("async_rst_irq", 32'(irq_o), 32'h0);
    check("async_rst_prdata", prdata, 32'h0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    hold_read(1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge pclk);
      exp_bit = (k >= 3) ? 32'h4 : 32'h0;
      check($sformatf("post_rst_padin_e%0d", k), prdata, exp_bit);
    end
    psel = 1'b0; penable = 1'b0;
    read_check("post_rst_dbcfg", 13, 32'h0);

    // ---------------- random inputs, bypass, both-edge: model check ----------------
    do_reset;
    base = $urandom;
    gpio_in_i = base;
    apb_write(11, 32'hFFFF_FFFF);
    apb_write(3, 32'hFFFF_FFFF);
    apb_write(6, 32'hFFFF_FFFF);
    read_check("rand_pre_status", 6, 32'h0);
    @(negedge pclk);
    hold_read(1);
    hist[0] = base; hist[1] = base;
    f_prev = base; st = '0;
    for (int c = 0; c < 200; c++) begin
      nv = hist[c+1];
      if (c < 197) nv = nv ^ ($urandom & $urandom & $urandom);
      hist[c+2] = nv;
      gpio_in_i = nv;
      @(negedge pclk);
      // Filtered value lags the pad by the synchroniser depth plus one edge.
      f = hist[c];
      exp_irq = (st != 0);
      st = st | (f ^ f_prev);
      f_prev = f;
      check("rand_padin", prdata, f);
      check("rand_irq", 32'(irq_o), 32'(exp_irq));
    end
    psel = 1'b0; penable = 1'b0;
    read_check("rand_status", 6, st);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb4_gpio_flt.md
Name: apb4_gpio_flt

Overview:
- Next-generation APB4 GPIO slave, parametrised in pin count and synchroniser depth.
- Adds per-pin digital debounce filters and a both-edge interrupt mode.
- Adds atomic set/clear/toggle output registers and a per-bit write-1-to-clear interrupt status, replacing clear-on-read.
- Sits on the peripheral APB4 bus; drives pad direction, output and IO-function mux; raises one level interrupt to the PLIC.

Parameters:
GPIO_NUM, 32, number of pins (1..32); pwdata/prdata bits above GPIO_NUM are ignored on write and read as 0.
SYNC_STAGES, 2, input synchroniser flops (>=2).
DB_CNT_W, 4, width of per-pin debounce counter and of the threshold field.

Ports:
pclk  in  1  clock
preset  in  1  asynchronous, active-high reset
paddr  in  32  APB address; word index = paddr[5:2]
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  tied 1
pslverr  out  1  tied 0
gpio_in_i  in  GPIO_NUM  raw pad inputs (asynchronous)
gpio_out_o  out  GPIO_NUM  pad output value
gpio_dir_o  out  GPIO_NUM  1 = output enable
gpio_iof_o  out  GPIO_NUM  1 = alternate function
irq_o  out  1  registered interrupt

Behaviour:
- Clocking/reset: one clock (pclk); reset (preset) is asynchronous and active-high. Reset clears every register, synchroniser, filter, counter and prescaler; all outputs and prdata read 0.
- Access: write when psel&penable&pwrite; read when psel&penable&~pwrite. Zero wait states. prdata is 0 outside a read access.
- Register map (index = paddr[5:2]):
  - 0 PADDIR rw.
  - 1 PADIN ro (filtered input).
  - 2 PADOUT rw.
  - 3 INTEN rw.
  - 4 INTTYPE0 rw.
  - 5 INTTYPE1 rw.
  - 6 INTSTATUS rw1c.
  - 7 IOFCFG rw.
  - 8 OUTSET wo.
  - 9 OUTCLR wo.
  - 10 OUTTGL wo.
  - 11 INTBOTH rw.
  - 12 DBEN rw.
  - 13 DBCFG rw: [15:0] DIV, [16+DB_CNT_W-1:16] THR.
  - Write-only registers read 0. Unmapped indices read 0 and ignore writes.
- Output writes take effect at the next edge:
  - PADOUT loads pwdata.
  - OUTSET: out |= wdata.
  - OUTCLR: out &= ~wdata.
  - OUTTGL: out ^= wdata.
- Input path: gpio_in_i passes through SYNC_STAGES flops to sync. The filter register filt_q feeds PADIN and edge detection.
- DBEN[i]=0 (bypass): filt_q[i] <= sync[i] every cycle. A pin change reaches PADIN after SYNC_STAGES+1 edges.
- Prescaler: counts 0..DIV. tick=1 in the cycle count==DIV, then wraps to 0; DIV=0 gives tick every cycle. A DBCFG write resets the prescaler to 0.
- Filter, DBEN[i]=1:
  - If sync[i]==filt_q[i], cnt[i] <= 0 (any cycle).
  - Else on tick: cnt[i]++; when cnt[i]+1 >= max(THR,1), filt_q[i] toggles and cnt[i] <= 0.
  - A glitch shorter than THR ticks never reaches filt_q.
- Edge events: rise = ~filt_q & filt_d; fall = filt_q & ~filt_d. They are evaluated in the cycle filt_q updates.
- Per-pin event select:
  - INTBOTH=1: rise|fall, overriding type bits.
  - Else {TYPE1,TYPE0}: 00 = level high, 01 = level low, 10 = rise, 11 = fall (levels on filt_q).
- Status: INTSTATUS[i] sets when INTEN[i] & event[i]. A write of 1 clears the bit. If set and W1C hit the same bit in the same cycle, set wins. Level-type bits re-set every cycle while the level persists.
- Reads have no side effects.
- irq_o <= |(INTSTATUS & INTEN), registered. Clearing INTEN masks irq but keeps status.
- Edge-mode latency: raw change to status set is SYNC_STAGES+1 edges (bypass); irq_o follows one edge later.
- Reset mid-debounce drops cnt and filt_q to 0. A pin high at release then produces a rise after SYNC_STAGES+1 edges; it is harmless because INTEN=0 after reset.

Decomposition:
- Extend the shared GPIO define package with:
  - register index constants for indices 8..13;
  - DBCFG field positions;
  - interrupt type encodings.
- One sub-module, gpio_debounce: per-pin counter plus filt_q register, instantiated GPIO_NUM times via generate. It takes tick, enable and threshold as inputs.
- Prescaler, synchroniser and register file stay in the top.

Test Plan:
1. Reset, then write PADOUT=0x0000_00F0, OUTSET=0x1, OUTCLR=0x10, OUTTGL=0x3 → gpio_out_o=0x0000_00E2; reads of indices 8/9/10 and 15 return 0.
2. INTEN=0x1, type rise, DBEN=0; drive gpio_in_i[0] 0→1 → INTSTATUS=0x1 at edge 3 (SYNC_STAGES=2), irq_o=1 at edge 4; write INTSTATUS=0x1 → irq_o=0 next edge.
3. INTBOTH[5]=1, INTEN[5]=1; pulse pin 5 high 10 cycles → status bit 5 set on rise; after W1C, set again on fall; the read itself leaves status unchanged.
4. DBEN[2]=1, DIV=3, THR=4; 12-cycle glitch on pin 2 → PADIN[2] stays 0. Hold high for 20 cycles → PADIN[2]=1 after 16 cycles plus sync latency.
5. Level-low on pin 7 held low, W1C written every cycle → status bit 7 stays 1 (set wins); irq_o stays 1.
6. Assert preset mid-debounce (cnt nonzero, irq_o=1) → all outputs 0 immediately, without waiting for pclk; counters restart from 0 after release.
